jitter_sample_gen: RTL and testbench

Consumes the free-running 12-bit stream from xor_prng and turns it into per-pixel sub-pixel jitter offsets for the primary ray generator. On a start pulse it pairs consecutive random words into (x, y) offsets for SAMPLES_PER_PIXEL samples. Each offset is a signed Q0.12 value in [-0.5, 0.5). Samples are buffered in a small FIFO and delivered downstream over a valid/ready handshake.

---
 rtl/jitter_sample_gen_pkg.sv | 29 ++
 rtl/jitter_sample_gen_fifo.sv | 56 +++++
 rtl/jitter_sample_gen.sv | 109 ++++++++++
 tb/tb_jitter_sample_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jitter_sample_gen_pkg.sv
// Shared types for the sub-pixel jitter generator:
// Q0.12 offset type, sample entry, FSM states.
package jitter_sample_gen_pkg;

  typedef logic signed [11:0] jitter_t;

  localparam logic [11:0] JITTER_BIAS = 12'h800;

  typedef struct packed {
    jitter_t    jx;
    jitter_t    jy;
    logic [7:0] idx;
    logic       last;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE,
    GEN_X,
    GEN_Y
  } state_t;

  // rand - 2048 is exact as a bias flip on the MSB
  function automatic jitter_t map_jitter(
    input logic [11:0] r
  );
    return jitter_t'(r ^ JITTER_BIAS);
  endfunction

endpackage

// File: rtl/jitter_sample_gen_fifo.sv
// Small synchronous FIFO, generic entry type.
// Full already accounts for a same-cycle pop.
module sample_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_valid,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH)) && !w_pop;
  assign w_push  = i_push && !o_full;
  assign o_valid = (r_cnt != '0);
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/jitter_sample_gen.sv
// Pairs consecutive PRNG words into (x,y) jitter
// samples for one pixel and queues them downstream.
module jitter_sample_gen
  import jitter_sample_gen_pkg::*;
#(
  parameter int SAMPLES_PER_PIXEL = 4,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rand_num,
  input  logic        start,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] jitter_x,
  output logic [11:0] jitter_y,
  output logic [7:0]  sample_idx,
  output logic        sample_last
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_x;
  logic [11:0] w_x_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        w_push;
  logic        w_last;
  logic        w_full;
  logic        w_empty;
  sample_t     w_entry;
  sample_t     w_head;

  assign w_last = (r_cnt == 8'(SAMPLES_PER_PIXEL - 1));

  assign w_entry = '{
    jx:   map_jitter(r_x),
    jy:   map_jitter(rand_num),
    idx:  r_cnt,
    last: w_last
  };

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = GEN_X;
          w_cnt_nxt   = '0;
        end
      end
      GEN_X: begin
        w_x_nxt     = rand_num;
        w_state_nxt = GEN_Y;
      end
      GEN_Y: begin
        // stall keeps x; y is re-drawn on the push cycle
        if (!w_full) begin
          w_push = 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = r_cnt + 8'd1;
            w_state_nxt = GEN_X;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sample_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign busy        = (r_state != IDLE) || !w_empty;
  assign jitter_x    = w_head.jx;
  assign jitter_y    = w_head.jy;
  assign sample_idx  = w_head.idx;
  assign sample_last = w_head.last;

endmodule

// File: tb/tb_jitter_sample_gen.sv
// Bench for jitter_sample_gen: directed table,
// hand sequences, then random traffic vs a queue model.
module tb_jitter_sample_gen;

  localparam int SPE   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [11:0] rand_num;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] jitter_x;
  logic [11:0] jitter_y;
  logic [7:0]  sample_idx;
  logic        sample_last;

  jitter_sample_gen #(
    .SAMPLES_PER_PIXEL (SPE),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rand_num    (rand_num),
    .start       (start),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .jitter_x    (jitter_x),
    .jitter_y    (jitter_y),
    .sample_idx  (sample_idx),
    .sample_last (sample_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: pixel generator as a transaction
  // stream. Phase 0 idle, 1 wants x word, 2 wants y.
  typedef struct {
    int x;
    int y;
    int idx;
    bit last;
  } smp_t;

  smp_t m_q[$];
  int   m_ph;
  int   m_cnt;
  int   m_x;

  task automatic mdl_reset();
    m_q.delete();
    m_ph  = 0;
    m_cnt = 0;
    m_x   = 0;
  endtask

  task automatic mdl_step(input bit st,
                          input bit rd,
                          input int rn);
    bit pop;
    pop = rd && (m_q.size() > 0);
    if (m_ph == 0) begin
      if (st) begin
        m_ph  = 1;
        m_cnt = 0;
      end
    end else if (m_ph == 1) begin
      m_x  = rn;
      m_ph = 2;
    end else if (m_q.size() < DEPTH || pop) begin
      m_q.push_back('{m_x - 2048, rn - 2048,
                      m_cnt, m_cnt == SPE - 1});
      if (m_cnt == SPE - 1) begin
        m_ph = 0;
      end else begin
        m_cnt++;
        m_ph = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
  endtask

  task automatic mdl_check();
    int ev;
    ev = (m_q.size() != 0);
    chk("valid", int'(out_valid), ev);
    chk("busy", int'(busy),
        int'((m_ph != 0) || (m_q.size() != 0)));
    if (ev != 0 && out_valid) begin
      chk("jx", int'($signed(jitter_x)), m_q[0].x);
      chk("jy", int'($signed(jitter_y)), m_q[0].y);
      chk("idx", int'(sample_idx), m_q[0].idx);
      chk("last", int'(sample_last), int'(m_q[0].last));
    end
  endtask

  // one cycle: drive at negedge, check, clock, advance model
  task automatic cyc(input bit st,
                     input bit rd,
                     input int rn);
    start     = st;
    out_ready = rd;
    rand_num  = 12'(rn);
    mdl_check();
    @(posedge clk);
    mdl_step(st, rd, rn);
    @(negedge clk);
  endtask

  typedef struct {
    bit st;
    bit rd;
    int rn;
    bit ev;
    bit eb;
    int ex;
    int ey;
    int ei;
    bit el;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t row(
    bit st, bit rd, int rn, bit ev, bit eb,
    int ex, int ey, int ei, bit el);
    vec_t v;
    v = '{st, rd, rn, ev, eb, ex, ey, ei, el};
    return v;
  endfunction

  initial begin
    // pixel A: rand 0,1,2.. from GEN_X; starts in
    // GEN_X are ignored. pixel B maps 4095 / 2048.
    tv[0]  = row(1, 1, 100,  0, 0,     0,     0, 0, 0);
    tv[1]  = row(1, 1, 0,    0, 1,     0,     0, 0, 0);
    tv[2]  = row(0, 1, 1,    0, 1,     0,     0, 0, 0);
    tv[3]  = row(1, 1, 2,    1, 1, -2048, -2047, 0, 0);
    tv[4]  = row(0, 1, 3,    0, 1,     0,     0, 0, 0);
    tv[5]  = row(0, 1, 4,    1, 1, -2046, -2045, 1, 0);
    tv[6]  = row(0, 1, 5,    0, 1,     0,     0, 0, 0);
    tv[7]  = row(0, 1, 6,    1, 1, -2044, -2043, 2, 0);
    tv[8]  = row(0, 1, 7,    0, 1,     0,     0, 0, 0);
    tv[9]  = row(0, 1, 8,    1, 1, -2042, -2041, 3, 1);
    tv[10] = row(1, 1, 9,    0, 0,     0,     0, 0, 0);
    tv[11] = row(1, 1, 4095, 0, 1,     0,     0, 0, 0);
    tv[12] = row(0, 1, 2048, 0, 1,     0,     0, 0, 0);
    tv[13] = row(0, 0, 77,   1, 1,  2047,     0, 0, 0);

    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    rand_num  = '0;
    mdl_reset();
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_jx", int'(jitter_x), 0);
    chk("rst_jy", int'(jitter_y), 0);
    chk("rst_idx", int'(sample_idx), 0);
    chk("rst_last", int'(sample_last), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      start     = tv[i].st;
      out_ready = tv[i].rd;
      rand_num  = 12'(tv[i].rn);
      chk($sformatf("t%0d_valid", i),
          int'(out_valid), int'(tv[i].ev));
      chk($sformatf("t%0d_busy", i),
          int'(busy), int'(tv[i].eb));
      if (tv[i].ev) begin
        chk($sformatf("t%0d_jx", i),
            int'($signed(jitter_x)), tv[i].ex);
        chk($sformatf("t%0d_jy", i),
            int'($signed(jitter_y)), tv[i].ey);
        chk($sformatf("t%0d_idx", i),
            int'(sample_idx), tv[i].ei);
        chk($sformatf("t%0d_last", i),
            int'(sample_last), int'(tv[i].el));
      end
      @(posedge clk);
      mdl_step(tv[i].st, tv[i].rd, tv[i].rn);
      @(negedge clk);
    end

    // asynchronous reset mid-pixel, FIFO holding an entry
    chk("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_jx", int'(jitter_x), 0);
    chk("arst_idx", int'(sample_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // backpressure: a whole pixel buffered
    cyc(1, 0, 11);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, int'($urandom_range(4095)));
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_busy", int'(busy), 1);
    chk("bp_head_idx", int'(sample_idx), 0);

    // second pixel stalls in GEN_Y on the full FIFO
    cyc(1, 0, 22);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, int'($urandom_range(4095)));
    cyc(0, 1, 3000);
    cyc(0, 0, 5);
    chk("stall_head_idx", int'(sample_idx), 1);
    cyc(0, 0, 6);

    // drain: pops every cycle, then idle
    for (int i = 0; i < 16; i++)
      cyc(0, 1, int'($urandom_range(4095)));
    chk("drain_busy", int'(busy), 0);
    chk("drain_valid", int'(out_valid), 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(3) == 0,
          $urandom_range(2) != 0,
          int'($urandom_range(4095)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
